// File: rtl/layernorm_pkg.sv
// layernorm_pkg: shared row geometry, saturation bounds and the int8 saturating add.
package layernorm_pkg;
   localparam int INPUT_NUM_DEF    = 768;
   localparam int LANES_DEF        = 32;
   localparam int SENTENCE_NUM_DEF = 128;
   localparam int BEATS            = INPUT_NUM_DEF / LANES_DEF;
   localparam int BEAT_CNT_W       = $clog2(BEATS);
   localparam int ROW_ID_W         = $clog2(SENTENCE_NUM_DEF);
   localparam logic signed [8:0] SAT_MAX = 9'sd127;
   localparam logic signed [8:0] SAT_MIN = -9'sd128;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic signed [8:0] s;
      s = $signed({a[7], a}) + $signed({b[7], b});
      return (s > SAT_MAX) ? SAT_MAX[7:0] : (s < SAT_MIN) ? SAT_MIN[7:0] : s[7:0];
   endfunction
endpackage

// File: rtl/sat_add_lanes.sv
// sat_add_lanes: LANES parallel int8 saturating adds of activation and residual.
module sat_add_lanes
   import layernorm_pkg::*;
#(
   parameter int LANES = LANES_DEF
) (
   input  logic [8*LANES-1:0] x_i,
   input  logic [8*LANES-1:0] res_i,
   output logic [8*LANES-1:0] sum_o
);
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign sum_o[k*8 +: 8] = sat_add8(x_i[k*8 +: 8], res_i[k*8 +: 8]);
   end
endmodule

// File: rtl/residual_add_row_packer.sv
// residual_add_row_packer: saturating residual add of a lane-serial int8 stream,
// packed into double-buffered token rows presented with active-low valid.
module residual_add_row_packer
   import layernorm_pkg::*;
#(
   parameter int INPUT_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 8,
   parameter int INPUT_NUM    = INPUT_NUM_DEF,
   parameter int LANES        = LANES_DEF,
   parameter int SENTENCE_NUM = SENTENCE_NUM_DEF,
   localparam int NB = INPUT_NUM / LANES,
   localparam int CW = (NB > 1) ? $clog2(NB) : 1,
   localparam int IW = $clog2(SENTENCE_NUM),
   localparam int LW = INPUT_WIDTH * LANES,
   localparam int RW = OUTPUT_WIDTH * INPUT_NUM
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [LW-1:0] in_x,
   input  logic [LW-1:0] in_res,
   input  logic          in_valid_n,
   output logic          in_ready,
   output logic [RW-1:0] row_data,
   output logic          row_valid_n,
   input  logic          row_ack,
   output logic [IW-1:0] row_id,
   output logic          row_last
);
   logic [1:0][RW-1:0] bank_q;
   logic [1:0][IW-1:0] tag_q;
   logic [CW-1:0]      beat_cnt_q;
   logic [IW-1:0]      wr_id_q;
   logic               wr_bank_q, rd_bank_q;
   logic [1:0]         full_cnt_q, full_cnt_d;
   logic [LW-1:0]      sum;
   logic               accept, last_beat, done, ack_v;

   sat_add_lanes #(.LANES(LANES)) u_add (.x_i(in_x), .res_i(in_res), .sum_o(sum));

   assign in_ready    = full_cnt_q != 2'd2;
   assign row_valid_n = full_cnt_q == 2'd0;
   assign row_data    = bank_q[rd_bank_q];
   assign row_id      = tag_q[rd_bank_q];
   assign row_last    = !row_valid_n && row_id == IW'(SENTENCE_NUM - 1);
   assign accept      = !in_valid_n && in_ready;
   assign last_beat   = beat_cnt_q == CW'(NB - 1);
   assign done        = accept && last_beat;
   assign ack_v       = row_ack && !row_valid_n;
   // Completion and ack in the same cycle cancel, keeping one bank presented.
   assign full_cnt_d  = full_cnt_q + {1'b0, done} - {1'b0, ack_v};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q     <= '0;
         tag_q      <= '0;
         beat_cnt_q <= '0;
         wr_id_q    <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         full_cnt_q <= '0;
      end else begin
         if (accept) begin
            bank_q[wr_bank_q][beat_cnt_q*LW +: LW] <= sum;
            beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
         end
         if (done) begin
            wr_bank_q        <= ~wr_bank_q;
            tag_q[wr_bank_q] <= wr_id_q;
            wr_id_q          <= (wr_id_q == IW'(SENTENCE_NUM - 1)) ? '0 : wr_id_q + 1'b1;
         end
         if (ack_v) rd_bank_q <= ~rd_bank_q;
         full_cnt_q <= full_cnt_d;
      end
   end
endmodule

// File: tb/tb_residual_add_row_packer.sv
// tb_residual_add_row_packer: directed checks of row packing, saturation,
// backpressure, simultaneous complete/ack, row_id wrap and async reset.
module tb_residual_add_row_packer;
   localparam int W = 8, N = 768, L = 32, NB = 24;
   logic             clk = 1'b0, rst_n = 1'b0;
   logic [L*W-1:0]   in_x = '0, in_res = '0;
   logic             in_valid_n = 1'b1, row_ack = 1'b0;
   logic             in_ready, row_valid_n, row_last;
   logic [N*W-1:0]   row_data;
   logic [6:0]       row_id;
   logic [31:0]      sx = 32'hFF7F9C64, sr = 32'h01809C64, sv = 32'h00FF807F;
   int               total = 0, passed = 0;

   residual_add_row_packer dut (
      .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_res(in_res), .in_valid_n(in_valid_n),
      .in_ready(in_ready), .row_data(row_data), .row_valid_n(row_valid_n),
      .row_ack(row_ack), .row_id(row_id), .row_last(row_last)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   function automatic logic [N*W-1:0] exp_row(input int seed, input bit sat);
      logic [N*W-1:0] r;
      logic [31:0] v;
      for (int e = 0; e < N; e++) begin
         v = e + seed;
         r[e*W +: W] = sat ? sv[(e%4)*8 +: 8] : v[7:0];
      end
      return r;
   endfunction

   task automatic chk_row(input string tag, input logic [N*W-1:0] exp);
      int idx;
      idx = 0;
      for (int e = N - 1; e >= 0; e--) if (row_data[e*W +: W] !== exp[e*W +: W]) idx = e;
      total++;
      assert (row_data === exp) passed++;
      else $error("FAIL %s: elem %0d got %h want %h", tag, idx, row_data[idx*W +: W], exp[idx*W +: W]);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int b, input int seed, input bit sat);
      logic [31:0] v;
      for (int k = 0; k < L; k++) begin
         v = b*L + k + seed;
         in_x[k*W +: W]   = sat ? sx[(k%4)*8 +: 8] : v[7:0];
         in_res[k*W +: W] = sat ? sr[(k%4)*8 +: 8] : 8'h00;
      end
      in_valid_n = 1'b0;
   endtask

   task automatic send_beat(input int b, input int seed, input bit sat);
      int n;
      n = 0;
      set_beat(b, seed, sat);
      while (!in_ready && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) chk("stall_timeout", in_ready, 1);
      step();
      in_valid_n = 1'b1;
   endtask

   task automatic send_beats(input int from, input int upto, input int seed, input bit sat);
      for (int b = from; b < upto; b++) send_beat(b, seed, sat);
   endtask

   task automatic ack();
      row_ack = 1'b1;
      step();
      row_ack = 1'b0;
   endtask

   initial begin
      step();
      chk("rst_valid_n", row_valid_n, 1);
      chk("rst_ready", in_ready, 1);
      chk("rst_row_id", row_id, 0);
      chk("rst_last", row_last, 0);
      chk_row("rst_data", '0);
      rst_n = 1'b1;
      step();
      chk("post_rst_valid_n", row_valid_n, 1);
      chk("post_rst_ready", in_ready, 1);

      send_beats(0, NB - 1, 0, 0);
      chk("row0_not_yet", row_valid_n, 1);
      send_beat(NB - 1, 0, 0);
      chk("row0_valid_n", row_valid_n, 0);
      chk("row0_id", row_id, 0);
      chk("row0_last", row_last, 0);
      chk_row("row0_data", exp_row(0, 0));
      ack();
      chk("row0_acked", row_valid_n, 1);

      send_beats(0, NB, 0, 1);
      chk("sat_valid_n", row_valid_n, 0);
      chk("sat_id", row_id, 1);
      chk_row("sat_data", exp_row(0, 1));
      ack();

      send_beats(0, NB, 3, 0);
      chk("bp_ready_one", in_ready, 1);
      send_beats(0, NB, 7, 0);
      chk("bp_ready_full", in_ready, 0);
      chk("bp_id", row_id, 2);
      chk_row("bp_data_a", exp_row(3, 0));
      set_beat(0, 11, 0);
      repeat (3) step();
      chk("bp_stalled", in_ready, 0);
      chk_row("bp_data_held", exp_row(3, 0));
      ack();
      chk("bp_ready_back", in_ready, 1);
      chk("bp_id_adv", row_id, 3);
      chk_row("bp_data_b", exp_row(7, 0));
      send_beats(0, NB, 11, 0);
      chk("bp_full_again", in_ready, 0);
      ack();
      chk("bp_id_c", row_id, 4);
      chk_row("bp_data_c", exp_row(11, 0));
      ack();
      chk("bp_drained", row_valid_n, 1);

      send_beats(0, NB, 13, 0);
      chk("sim_id_d", row_id, 5);
      send_beats(0, NB - 1, 17, 0);
      row_ack = 1'b1;
      send_beat(NB - 1, 17, 0);
      row_ack = 1'b0;
      chk("sim_valid_n", row_valid_n, 0);
      chk("sim_ready", in_ready, 1);
      chk("sim_id_e", row_id, 6);
      chk_row("sim_data_e", exp_row(17, 0));
      ack();
      chk("sim_one_left", row_valid_n, 1);
      ack();
      chk("empty_ack_valid_n", row_valid_n, 1);
      chk("empty_ack_ready", in_ready, 1);

      for (int r = 0; r < 128; r++) begin
         send_beats(0, NB, r, 0);
         chk($sformatf("wrap_id_%0d", r), row_id, (7 + r) % 128);
         chk($sformatf("wrap_last_%0d", r), row_last, ((7 + r) % 128) == 127);
         ack();
      end

      send_beats(0, NB, 5, 0);
      send_beats(0, 10, 9, 0);
      chk("pre_rst_valid_n", row_valid_n, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid_n", row_valid_n, 1);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_id", row_id, 0);
      chk("mid_rst_last", row_last, 0);
      chk_row("mid_rst_data", '0);
      step();
      rst_n = 1'b1;
      send_beats(0, NB - 1, 21, 0);
      chk("fresh_not_yet", row_valid_n, 1);
      send_beat(NB - 1, 21, 0);
      chk("fresh_valid_n", row_valid_n, 0);
      chk("fresh_id", row_id, 0);
      chk_row("fresh_data", exp_row(21, 0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/residual_add_row_packer.md
Name: residual_add_row_packer

Overview:
- Upstream neighbour of the per-token layernorm stage.
- Accepts a lane-serial stream of int8 activations plus the matching int8 residual operand, LANES elements per beat.
- Forms the saturating residual sum and packs a full token row of INPUT_NUM elements.
- Presents completed rows to layernorm on a row-wide bus with active-low valid.
- Double-buffered, so the stream keeps flowing while layernorm holds a row.

Parameters:
- INPUT_WIDTH, 8, element width of the stream and residual inputs (signed two's complement).
- OUTPUT_WIDTH, 8, element width of the packed row (signed, saturated). Must equal INPUT_WIDTH.
- INPUT_NUM, 768, elements per token row.
- LANES, 32, elements per input beat. INPUT_NUM must be a multiple of LANES; BEATS = INPUT_NUM/LANES = 24.
- SENTENCE_NUM, 128, tokens per sentence; row_id wraps at this count.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_x, input, INPUT_WIDTH*LANES, activation lanes. Lane k is at bits [(k+1)*W-1 : k*W].
- in_res, input, INPUT_WIDTH*LANES, residual lanes, same packing as in_x.
- in_valid_n, input, 1, active-low beat valid.
- in_ready, output, 1, high when a beat can be accepted.
- row_data, output, OUTPUT_WIDTH*INPUT_NUM, packed row. Element e is at bits [(e+1)*W-1 : e*W].
- row_valid_n, output, 1, active-low: row_data holds a complete row.
- row_ack, input, 1, active-high single-cycle consume pulse from downstream.
- row_id, output, clog2(SENTENCE_NUM), token index of the presented row.
- row_last, output, 1, high with row valid when row_id == SENTENCE_NUM-1.

Behaviour:
- Reset (async, rst_n low):
  - beat_cnt = 0, wr_bank = 0, rd_bank = 0, full_cnt = 0.
  - wr_id = 0, rd_id = 0.
  - Both banks cleared to 0.
  - Resulting outputs: row_valid_n = 1, in_ready = 1, row_data = 0, row_id = 0, row_last = 0.
  - Reset mid-row discards any partial row and all full banks.
- Accept condition: accept = !in_valid_n && in_ready.
  - in_ready = (full_cnt != 2), combinational from registered state. There is no combinational path from row_ack or in_valid_n to in_ready.
- Lane arithmetic, per lane:
  - sum = sext9(x) + sext9(res).
  - Clip to [-128, 127]: 9-bit sum > 127 gives 127; < -128 gives -128; otherwise sum[7:0].
- On accept, the LANES results are written into bank[wr_bank] at elements beat_cnt*LANES .. beat_cnt*LANES+LANES-1.
  - If beat_cnt < BEATS-1, then beat_cnt++.
  - If beat_cnt == BEATS-1 (row complete):
    - beat_cnt = 0.
    - wr_bank toggles.
    - Bank tagged with wr_id; wr_id increments, wrapping SENTENCE_NUM-1 -> 0.
    - full_cnt++.
- Output side:
  - row_valid_n = (full_cnt == 0).
  - row_data = bank[rd_bank].
  - row_id = tag of rd_bank.
  - row_last = !row_valid_n && row_id == SENTENCE_NUM-1.
- On row_ack while row_valid_n == 0: rd_bank toggles, full_cnt--.
  - row_ack while row_valid_n == 1 is ignored.
  - Presented row_data is stable until it is acked.
- Latency: the last beat accepted at edge N gives row_valid_n = 0 in the cycle after edge N (1 cycle), provided the other bank was not already presenting.
- Simultaneous row completion and valid ack in the same cycle:
  - full_cnt is unchanged.
  - Both banks toggle.
  - The new row is presented next cycle.
- full_cnt == 2: in_ready = 0 and beats are held off. An ack that cycle frees a bank; in_ready = 1 on the next cycle.
- full_cnt == 0 with ack: no state change.
- The bank being filled is never the bank being presented. This is guaranteed by full_cnt <= 2.
- Throughput: one beat per cycle sustained while downstream acks at least once per BEATS cycles.

Decomposition:
- Shared package layernorm_pkg:
  - BEATS and BEAT_CNT_W constants.
  - ROW_ID_W = clog2(SENTENCE_NUM).
  - SAT_MAX = 127 and SAT_MIN = -128.
  - A sat_add8 function: signed 8 + 8 -> 8 with clip.
- One sub-module, sat_add_lanes: combinational, LANES parallel sat_add8 instances, in_x/in_res -> LANES*8 result.
- The top holds the two banks, counters, the full_cnt FSM and the output mux.

Test Plan:
- Post-reset: rst_n low, then high with no input -> row_valid_n = 1, in_ready = 1, row_id = 0, row_data all zero.
- One row: 24 back-to-back beats with in_x lane = beat*32+k (low 8 bits) and in_res = 0 -> row_valid_n low exactly 1 cycle after the 24th accept; element e = e[7:0] as signed; row_id = 0.
- Saturation: x = 100, res = 100 -> 127; x = -100, res = -100 -> -128; x = 127, res = -128 -> -1; x = -1, res = 1 -> 0.
- Backpressure: three rows streamed with no row_ack -> in_ready falls after the 2nd row completes; the 3rd row's first beat is stalled. One row_ack -> in_ready = 1 next cycle, row_id advances 0 -> 1, and the 3rd row is accepted intact.
- Simultaneous event: ack row 0 on the same cycle the last beat of row 1 is accepted -> full_cnt stays 1 and row 1 is presented next cycle with row_id = 1.
- Wrap and reset: stream 128 rows acking each -> row_last high only on row_id 127, and the next row has row_id 0. Assert rst_n low after 10 beats of a row -> all outputs at reset values; the next full row is complete only after 24 fresh beats.
